// File: rtl/aes_inv_key_gen.sv
//-----------------------------------------------------------------------------
// aes_inv_key_gen
//
// Reverse AES-128 key expansion for the decryption datapath. A round-10 key
// is loaded on start_i. Round keys 10 down to 0 are then presented on a
// valid/ready stream. Each step back needs SubWord(RotWord(w3 ^ w2)), and
// that value comes from an S-box shared with the forward key generator. The
// S-box is reached through a one-cycle request strobe and answers after a
// fixed latency.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   start_i      load key_i and begin (honoured only when idle)
//   key_i        round-NUM_ROUNDS key, [127:96]=w0 .. [31:0]=w3
//   key_o        current round key, same word order
//   rnd_o        round index of key_o
//   key_valid_o  key_o/rnd_o valid
//   key_ready_i  consumer accepts key_o
//   sub_o        RotWord(w3 ^ w2) sent to the shared S-box
//   sub_valid_o  S-box request strobe (one cycle)
//   sub_i        SubWord(sub_o), valid SBOX_LAT cycles after sub_valid_o
//   busy_o       high whenever not idle
//   done_o       one-cycle pulse after the round-0 key is accepted
//
// Only NUM_ROUNDS = 10 (AES-128) is supported. SBOX_LAT must be 1..4.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_inv_key_gen #(
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic [127:0] key_o,
    output logic [3:0]   rnd_o,
    output logic         key_valid_o,
    input  logic         key_ready_i,
    output logic [31:0]  sub_o,
    output logic         sub_valid_o,
    input  logic [31:0]  sub_i,
    output logic         busy_o,
    output logic         done_o
);

    localparam int CNT_W = 2;   // holds SBOX_LAT-1 for SBOX_LAT up to 4

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_SUB,
        ST_WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [127:0]       key_q;
    logic [3:0]         rnd_q;
    logic [7:0]         rcon_q;
    logic [7:0]         rcon_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic [31:0]        w0, w1, w2, w3;
    logic [31:0]        t_word;
    logic [31:0]        rot_word;

    assign {w0, w1, w2, w3} = key_q;

    // w3 of the previous round key is w3 ^ w2 of this one. Its RotWord is
    // what the forward schedule fed to the S-box.
    assign t_word   = w3 ^ w2;
    assign rot_word = {t_word[23:0], t_word[31:24]};

    // Divide rcon by x in GF(2^8). When the lsb is set, first add the
    // reduction polynomial (0x11B). The result then shifts down, and its top
    // bit comes from the x^8 term.
    always_comb begin
        if (rcon_q[0]) begin
            rcon_nxt = ((rcon_q ^ 8'h1B) >> 1) | 8'h80;
        end else begin
            rcon_nxt = rcon_q >> 1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned,
    // so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i)     state_nxt = ST_EMIT;
            ST_EMIT: if (key_ready_i) state_nxt = (rnd_q == 4'd0) ? ST_IDLE : ST_SUB;
            ST_SUB:                   state_nxt = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_nxt = ST_EMIT;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            rnd_q  <= '0;
            rcon_q <= 8'h36;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_EMIT) && key_ready_i && (rnd_q == 4'd0);
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q  <= key_i;
                        rnd_q  <= 4'(NUM_ROUNDS);
                        rcon_q <= 8'h36;
                    end
                end
                ST_SUB: begin
                    cnt_q <= CNT_W'(SBOX_LAT - 1);
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        // S-box answer is valid only in this last WAIT cycle.
                        key_q  <= {w0 ^ sub_i ^ {rcon_q, 24'h0},
                                   w1 ^ w0,
                                   w2 ^ w1,
                                   w3 ^ w2};
                        rnd_q  <= rnd_q - 4'd1;
                        rcon_q <= rcon_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // key_q does not change during SUB and WAIT. So sub_o holds steady from
    // the request cycle until the S-box answer is sampled.
    always_comb begin
        key_valid_o = 1'b0;
        sub_valid_o = 1'b0;
        sub_o       = '0;
        busy_o      = 1'b1;
        case (state)
            ST_IDLE: busy_o = 1'b0;
            ST_EMIT: key_valid_o = 1'b1;
            ST_SUB: begin
                sub_o       = rot_word;
                sub_valid_o = 1'b1;
            end
            ST_WAIT: sub_o = rot_word;
            default: busy_o = 1'b0;
        endcase
    end

    assign key_o  = key_q;
    assign rnd_o  = rnd_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_aes_inv_key_gen.sv
//-----------------------------------------------------------------------------
// tb_aes_inv_key_gen
//
// Self-checking bench. There are two instances: SBOX_LAT = 1 and
// SBOX_LAT = 3. Each one has its own S-box responder. The responder drives
// random junk on sub_i except in the cycle where the answer is due.
//
// The reference model is the FIPS-197 key schedule. It runs backwards over
// the 44-word array w[], and it uses an S-box that is built from GF(2^8)
// inversion plus the affine map.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_inv_key_gen;

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [31:0]  FIPS_SUB = 32'h5c006e57;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [2];
    logic         start     [2];
    logic [127:0] key_in    [2];
    logic [127:0] key_out   [2];
    logic [3:0]   rnd       [2];
    logic         key_valid [2];
    logic         key_ready [2];
    logic [31:0]  sub_out   [2];
    logic         sub_valid [2];
    logic [31:0]  sub_in    [2];
    logic         busy      [2];
    logic         done      [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]   sbox_tab  [256];
    logic [127:0] model_key [2][11];
    logic [31:0]  model_sub [2][10];

    bit           active     [2];
    int           exp_next   [2];
    bit           prev_stall [2];
    logic [127:0] held_key   [2];
    logic [3:0]   held_rnd   [2];
    logic [31:0]  first_sub  [2];
    bit           sub_seen   [2];
    logic [127:0] acc_key    [2][11];
    int           start_cyc  [2];

    // ---------------------------------------------------------------
    // Reference arithmetic
    // ---------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                              ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Run the FIPS-197 expansion backwards from the last four words.
    task automatic build_model(input int idx, input logic [127:0] k);
        logic [31:0] w  [44];
        logic [7:0]  rc [11];
        logic [31:0] tmp;
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
        {w[40], w[41], w[42], w[43]} = k;
        for (int i = 43; i >= 4; i--) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = sub_word(rot_word(tmp)) ^ {rc[i/4], 24'h0};
            w[i-4] = w[i] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) model_key[idx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 0; r < 10; r++)  model_sub[idx][r] = rot_word(w[4*r+3]);
    endtask

    // ---------------------------------------------------------------
    // DUTs and S-box responders
    // ---------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        bit          pv [LAT];
        bit [31:0]   pd [LAT];
        logic [31:0] junk;

        aes_inv_key_gen #(
            .NUM_ROUNDS (10),
            .SBOX_LAT   (LAT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .start_i     (start[g]),
            .key_i       (key_in[g]),
            .key_o       (key_out[g]),
            .rnd_o       (rnd[g]),
            .key_valid_o (key_valid[g]),
            .key_ready_i (key_ready[g]),
            .sub_o       (sub_out[g]),
            .sub_valid_o (sub_valid[g]),
            .sub_i       (sub_in[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g])
        );

        always @(posedge clk) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            pv[0] <= sub_valid[g];
            pd[0] <= sub_word(sub_out[g]);
            junk  <= $urandom;
        end

        assign sub_in[g] = pv[LAT-1] ? pd[LAT-1] : junk;
    end

    // ---------------------------------------------------------------
    // Checking and stream monitor
    // ---------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor(input int idx);
        if (!active[idx] || rst[idx]) return;
        if (prev_stall[idx]) begin
            check("stall_valid", 128'(key_valid[idx]), 128'(1));
            check("stall_key", key_out[idx], held_key[idx]);
            check("stall_rnd", 128'(rnd[idx]), 128'(held_rnd[idx]));
        end
        if (sub_valid[idx]) begin
            check("sub_with_valid", 128'(key_valid[idx]), 128'(0));
            if (exp_next[idx] >= 0 && exp_next[idx] < 10) begin
                check("sub_o", 128'(sub_out[idx]), 128'(model_sub[idx][exp_next[idx]]));
            end else begin
                check("sub_unexpected", 128'(1), 128'(0));
            end
            if (!sub_seen[idx]) begin
                first_sub[idx] = sub_out[idx];
                sub_seen[idx]  = 1'b1;
            end
        end
        prev_stall[idx] = 1'b0;
        if (key_valid[idx]) begin
            if (exp_next[idx] < 0) begin
                check("extra_key", 128'(1), 128'(0));
            end else begin
                check("rnd_o", 128'(rnd[idx]), 128'(exp_next[idx]));
                check("key_o", key_out[idx], model_key[idx][exp_next[idx]]);
                if (key_ready[idx]) begin
                    acc_key[idx][exp_next[idx]] = key_out[idx];
                    exp_next[idx]--;
                end else begin
                    prev_stall[idx] = 1'b1;
                    held_key[idx]   = key_out[idx];
                    held_rnd[idx]   = rnd[idx];
                end
            end
        end
    endtask

    task automatic tick(input int idx);
        @(negedge clk);
        monitor(idx);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_reset(input int idx);
        check("rst_key_o", key_out[idx], 128'(0));
        check("rst_rnd_o", 128'(rnd[idx]), 128'(0));
        check("rst_key_valid", 128'(key_valid[idx]), 128'(0));
        check("rst_sub_o", 128'(sub_out[idx]), 128'(0));
        check("rst_sub_valid", 128'(sub_valid[idx]), 128'(0));
        check("rst_busy", 128'(busy[idx]), 128'(0));
        check("rst_done", 128'(done[idx]), 128'(0));
    endtask

    task automatic do_start(input int idx, input logic [127:0] k);
        build_model(idx, k);
        start[idx]      = 1'b1;
        key_in[idx]     = k;
        key_ready[idx]  = 1'b1;
        active[idx]     = 1'b1;
        exp_next[idx]   = 10;
        prev_stall[idx] = 1'b0;
        sub_seen[idx]   = 1'b0;
        start_cyc[idx]  = cyc;
        tick(idx);
        start[idx]  = 1'b0;
        key_in[idx] = {$urandom, $urandom, $urandom, $urandom};
        check("valid_at_start_plus1", 128'(key_valid[idx]), 128'(1));
    endtask

    // Drive one run to completion. Options: random ready, one 5-cycle stall
    // at a chosen round, a stray start pulse at a chosen round, or a reset
    // during WAIT at a chosen round (the reset ends the run early).
    task automatic run(input int idx, input bit rand_ready, input int stall_rnd,
                       input int pulse_rnd, input int rst_rnd,
                       output int lat, output bit aborted);
        bit stalled;
        bit pulsed;
        int stall_left;
        stalled    = 1'b0;
        pulsed     = 1'b0;
        stall_left = 0;
        lat        = -1;
        aborted    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (done[idx]) begin
                lat = cyc - start_cyc[idx];
                break;
            end
            if (rst_rnd >= 0 && busy[idx] && !key_valid[idx] && !sub_valid[idx]
                && rnd[idx] == 4'(rst_rnd)) begin
                rst[idx] = 1'b1;
                tick(idx);
                rst[idx]    = 1'b0;
                active[idx] = 1'b0;
                chk_reset(idx);
                aborted = 1'b1;
                return;
            end
            if (stall_left > 0) begin
                key_ready[idx] = 1'b0;
                stall_left--;
            end else if (stall_rnd >= 0 && !stalled && key_valid[idx]
                         && rnd[idx] == 4'(stall_rnd)) begin
                key_ready[idx] = 1'b0;
                stall_left     = 4;
                stalled        = 1'b1;
            end else begin
                key_ready[idx] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (pulse_rnd >= 0 && !pulsed && busy[idx] && rnd[idx] == 4'(pulse_rnd)) begin
                start[idx]  = 1'b1;
                key_in[idx] = {$urandom, $urandom, $urandom, $urandom};
                pulsed      = 1'b1;
            end
            tick(idx);
            start[idx] = 1'b0;
        end
        if (lat < 0) begin
            check("done_timeout", 128'(0), 128'(1));
            active[idx] = 1'b0;
            return;
        end
        check("all_keys_accepted", 128'(exp_next[idx] + 1), 128'(0));
        active[idx]    = 1'b0;
        key_ready[idx] = 1'b1;
        tick(idx);
        check("done_one_cycle", 128'(done[idx]), 128'(0));
        check("idle_after_done", 128'(busy[idx]), 128'(0));
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int lat;
        bit ab;

        init_sbox();
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            start[i]     = 1'b0;
            key_in[i]    = '0;
            key_ready[i] = 1'b1;
            active[i]    = 1'b0;
            exp_next[i]  = -1;
        end
        tick(0);
        tick(0);
        chk_reset(0);
        chk_reset(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick(0);

        // FIPS-197 A.1 vector, ready always high, SBOX_LAT = 1
        do_start(0, FIPS_K10);
        run(0, 1'b0, -1, -1, -1, lat, ab);
        check("lat_fips_l1", 128'(lat), 128'(32));
        check("fips_first_sub", 128'(first_sub[0]), 128'(FIPS_SUB));
        check("fips_k10", acc_key[0][10], FIPS_K10);
        check("fips_k9", acc_key[0][9], FIPS_K9);
        check("fips_k0", acc_key[0][0], FIPS_K0);

        // Backpressure: 5-cycle stall at round 7, then random ready
        do_start(0, FIPS_K10);
        run(0, 1'b1, 7, -1, -1, lat, ab);
        check("bp_k0", acc_key[0][0], FIPS_K0);

        // Stray start at round 5 is ignored, new start after done accepted
        do_start(0, FIPS_K10);
        run(0, 1'b0, -1, 5, -1, lat, ab);
        check("lat_stray_start", 128'(lat), 128'(32));
        check("stray_k0", acc_key[0][0], FIPS_K0);
        do_start(0, {$urandom, $urandom, $urandom, $urandom});
        run(0, 1'b1, -1, -1, -1, lat, ab);

        // Reset during WAIT at round 4, then a fresh full run
        do_start(0, FIPS_K10);
        run(0, 1'b0, -1, -1, 4, lat, ab);
        check("rst_aborted", 128'(ab), 128'(1));
        tick(0);
        do_start(0, FIPS_K10);
        run(0, 1'b0, -1, -1, -1, lat, ab);
        check("post_rst_k0", acc_key[0][0], FIPS_K0);

        // All-zero key, compared against the model every round
        do_start(0, 128'h0);
        run(0, 1'b1, -1, -1, -1, lat, ab);

        for (int r = 0; r < 4; r++) begin
            do_start(0, {$urandom, $urandom, $urandom, $urandom});
            run(0, 1'b1, -1, -1, -1, lat, ab);
        end

        // SBOX_LAT = 3 instance
        do_start(1, FIPS_K10);
        run(1, 1'b0, -1, -1, -1, lat, ab);
        check("lat_fips_l3", 128'(lat), 128'(52));
        check("l3_first_sub", 128'(first_sub[1]), 128'(FIPS_SUB));
        check("l3_k9", acc_key[1][9], FIPS_K9);
        check("l3_k0", acc_key[1][0], FIPS_K0);

        do_start(1, FIPS_K10);
        run(1, 1'b0, -1, -1, 4, lat, ab);
        check("l3_rst_aborted", 128'(ab), 128'(1));
        tick(1);

        for (int r = 0; r < 3; r++) begin
            do_start(1, {$urandom, $urandom, $urandom, $urandom});
            run(1, 1'b1, 3, -1, -1, lat, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_gen.md
Name: aes_inv_key_gen

Overview:
- Runs the AES-128 key expansion in reverse for the decryption datapath.
- Loads the final (round-NUM_ROUNDS) round key, then emits round keys NUM_ROUNDS down to 0 over a valid/ready stream.
- Shares the external S-box with the forward key generator through a request port and a fixed-latency return port.
- Sits between the key register file and the inverse-cipher round logic.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported.
SBOX_LAT, 1, cycles from the sub_valid_o cycle to valid sub_i; legal range 1..4.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start_i  in  1  load key_i and begin; honoured only in IDLE.
key_i  in  128  round-NUM_ROUNDS key; [127:96]=w0 ... [31:0]=w3.
key_o  out  128  current round key, same word order.
rnd_o  out  4  round index of key_o.
key_valid_o  out  1  key_o/rnd_o valid.
key_ready_i  in  1  consumer accepts key_o.
sub_o  out  32  RotWord word sent to the shared S-box.
sub_valid_o  out  1  S-box request strobe, one cycle.
sub_i  in  32  SubWord(sub_o), valid SBOX_LAT cycles after sub_valid_o.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- All ports are interpreted as stated under "Already decided": one clock, synchronous active-high reset.
- Reset values: key_o=0, rnd_o=0, key_valid_o=0, sub_o=0, sub_valid_o=0, busy_o=0, done_o=0, FSM=IDLE, rcon register=0x36.
- Reset asserted mid-operation returns to IDLE at the next edge. The current key is discarded and any S-box response still in flight is ignored.
- FSM states: IDLE, EMIT, SUB, WAIT.
- IDLE:
  - On start_i: key register<=key_i, rnd<=NUM_ROUNDS, rcon<=0x36, go to EMIT.
  - key_valid_o rises the cycle after start_i.
- EMIT:
  - key_valid_o=1. key_o and rnd_o are held stable until the handshake (key_valid_o & key_ready_i).
  - On handshake with rnd==0: go to IDLE, done_o=1 for the next cycle.
  - On handshake with rnd!=0: go to SUB.
  - start_i is ignored in EMIT.
- SUB:
  - t = w3 ^ w2.
  - sub_o = {t[23:0], t[31:24]} (RotWord), sub_valid_o=1 for this cycle only.
  - Load the wait counter with SBOX_LAT-1, go to WAIT.
- WAIT:
  - sub_o is held.
  - When the counter reaches 0, sample sub_i and register the previous key, then go to EMIT:
    - w3' = w3 ^ w2
    - w2' = w2 ^ w1
    - w1' = w1 ^ w0
    - w0' = w0 ^ sub_i ^ {rcon, 24'h0}
  - In the same cycle: rnd <= rnd-1, and rcon is divided by x in GF(2^8):
    - lsb=0: rcon>>1
    - lsb=1: (rcon^0x1B)>>1 | 0x80
  - Required rcon sequence: 36, 1B, 80, 40, 20, 10, 08, 04, 02, 01.
- Timing:
  - Round period with key_ready_i held high is 2+SBOX_LAT cycles.
  - 11 keys with SBOX_LAT=1: first valid at start+1, last valid at start+31.
- Backpressure:
  - key_ready_i low in EMIT stalls indefinitely with no state change.
  - key_ready_i is ignored outside EMIT.
- start_i while busy_o=1 is dropped, with no effect on the current key, round or rcon.
- sub_i is sampled only in the final WAIT cycle. Any other value on it is don't-care.

Test Plan:
1. FIPS-197 A.1: start with key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1 -> rnd 10 key=d014f9a8..., first sub_o=5c006e57, rnd 9 key=ac7766f319fadc2128d12941575c006e, rnd 0 key=2b7e151628aed2a6abf7158809cf4f3c, done_o at start+32.
2. Backpressure: hold key_ready_i=0 for 5 cycles at rnd 7 -> key_o/rnd_o stable, no sub_valid_o, sequence resumes with identical keys; randomized ready gives same 11 keys.
3. SBOX_LAT=3 build, same key -> sub_i sampled 3 cycles after sub_valid_o, round period 5 cycles, same key sequence.
4. start_i pulsed at rnd 5 with a different key_i -> ignored, original sequence completes; start_i the cycle after done_o -> new run accepted.
5. rst asserted during WAIT at rnd 4 -> next cycle all outputs at reset values, IDLE; fresh start produces correct sequence from rnd 10.
6. All-zero key_i -> rnd 0 key equals known inverse expansion from model; check rcon sequence 36..01 via w0' vs model every round.
